// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, ALU opcodes and forwarding helpers
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // ALU opcodes shared with the ALU and the ALU controller
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_MUL = 3'd6;
  localparam logic [2:0] ALU_SUB = 3'd7;

  // Where a source operand comes from
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_src_e;

  // x0 beats everything; the EX instruction is younger than the WB one, so it wins
  function automatic fwd_src_e fwd_select(input logic is_x0, input logic ex_hit,
                                          input logic wb_hit);
    if (is_x0)       return FWD_ZERO;
    else if (ex_hit) return FWD_EX;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - integer register file, 2 async reads, 1 sync write, x0 hardwired to zero
module reg_file #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];

  // Clear every entry on reset; writes to x0 are dropped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute stage with register file, EX/WB forwarding and stage registers
module id_ex_stage #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [AW-1:0]   RS1addr_i,
  input  logic [AW-1:0]   RS2addr_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            ALUSrc_i,
  input  logic [2:0]      ALUCtrl_i,
  input  logic            RegWrite_i,
  input  logic [AW-1:0]   RDaddr_i,
  input  logic [XLEN-1:0] EXresult_i,
  input  logic            WBwrite_i,
  input  logic [AW-1:0]   WBaddr_i,
  input  logic [XLEN-1:0] WBdata_i,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic [2:0]      ALUCtrl_o,
  output logic            RegWrite_o,
  output logic [AW-1:0]   RDaddr_o,
  output logic            valid_o
);

  import cpu_pkg::*;

  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  logic            valid_q,    valid_d;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   rd_q,       rd_d;
  logic [2:0]      aluctrl_q,  aluctrl_d;
  logic [XLEN-1:0] data1_q,    data1_d;
  logic [XLEN-1:0] data2_q,    data2_d;

  fwd_src_e        src1;
  fwd_src_e        src2;
  logic            ex_writes;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  reg_file #(
    .XLEN(XLEN),
    .NREG(NREG),
    .AW  (AW)
  ) u_reg_file (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (WBwrite_i),
    .waddr_i (WBaddr_i),
    .wdata_i (WBdata_i),
    .raddr1_i(RS1addr_i),
    .raddr2_i(RS2addr_i),
    .rdata1_o(rf_rdata1),
    .rdata2_o(rf_rdata2)
  );

  // The instruction sitting on our outputs is the one the ALU is working on
  assign ex_writes = valid_q && regwrite_q;

  // Resolve both source operands: x0, then EX result, then WB write-through, then register file
  always_comb begin
    src1 = fwd_select(RS1addr_i == '0, ex_writes && (rd_q == RS1addr_i),
                      WBwrite_i && (WBaddr_i == RS1addr_i));
    src2 = fwd_select(RS2addr_i == '0, ex_writes && (rd_q == RS2addr_i),
                      WBwrite_i && (WBaddr_i == RS2addr_i));
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    unique case (src1)
      FWD_ZERO: rs1_val = '0;
      FWD_EX:   rs1_val = EXresult_i;
      FWD_WB:   rs1_val = WBdata_i;
      default:  rs1_val = rf_rdata1;
    endcase
    unique case (src2)
      FWD_ZERO: rs2_val = '0;
      FWD_EX:   rs2_val = EXresult_i;
      FWD_WB:   rs2_val = WBdata_i;
      default:  rs2_val = rf_rdata2;
    endcase
  end

  // Next stage contents: flush inserts a bubble, stall holds, otherwise capture
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    aluctrl_d  = aluctrl_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      rd_d       = '0;
      aluctrl_d  = '0;
      data1_d    = '0;
      data2_d    = '0;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      regwrite_d = RegWrite_i && valid_i;
      rd_d       = RDaddr_i;
      aluctrl_d  = ALUCtrl_i;
      data1_d    = rs1_val;
      data2_d    = ALUSrc_i ? imm_i : rs2_val;
    end
  end

  // Stage registers, cleared asynchronously on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      aluctrl_q  <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      aluctrl_q  <= aluctrl_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
    end
  end

  assign valid_o    = valid_q;
  assign RegWrite_o = regwrite_q;
  assign RDaddr_o   = rd_q;
  assign ALUCtrl_o  = aluctrl_q;
  assign data1_o    = data1_q;
  assign data2_o    = data2_q;

endmodule
